// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch slice.
package mips_fetch_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetch_state_t;

    localparam word_t DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam word_t DEFAULT_PC_INC       = 32'd4;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory handshake, decode handoff and redirect inputs.
interface fetch_sequencer_if;
    import mips_fetch_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;
    logic  instr_valid;
    word_t instr_word;
    word_t instr_pc;
    logic  instr_ready;
    logic  branch_taken;
    word_t branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_word, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_word, instr_pc,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
    );

endinterface

// File: rtl/pc_register.sv
// Program counter plus a one-entry pending redirect captured while a fetch is in flight.
module pc_register
    import mips_fetch_pkg::*;
#(
    parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter word_t PC_INC       = DEFAULT_PC_INC
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load_seq,
    input  logic  load_target,
    input  logic  load_pending,
    input  logic  capture_pending,
    input  word_t target,
    output word_t pc,
    output logic  pending_valid
);

    word_t pending_target;
    word_t target_aligned;
    word_t next_pc;

    assign target_aligned = align_word(target);

    // A same-cycle target always beats a previously captured one.
    always_comb begin
        next_pc = pc;
        if (load_target) begin
            next_pc = target_aligned;
        end else if (load_pending) begin
            next_pc = pending_target;
        end else if (load_seq) begin
            next_pc = pc + PC_INC;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc             <= align_word(RESET_VECTOR);
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else begin
            pc <= next_pc;
            if (capture_pending) begin
                pending_valid  <= 1'b1;
                pending_target <= target_aligned;
            end else if (load_target || load_pending) begin
                pending_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Handshake-driven fetch controller: one memory transaction per instruction,
// held for decode until accepted, with redirects discarding stale fetches.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter word_t PC_INC       = DEFAULT_PC_INC
) (
    input  logic               clock,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    fetch_state_t state;
    word_t        pc;
    logic         pending_valid;

    logic  imem_req;
    logic  instr_valid;
    word_t instr_word;
    word_t instr_pc;

    logic in_req;
    logic in_hold;
    logic load_seq;
    logic load_target;
    logic load_pending;
    logic capture_pending;
    logic fetch_good;

    assign in_req  = (state == REQ);
    assign in_hold = (state == HOLD);

    // An ack only delivers a usable instruction when no redirect is outstanding.
    assign fetch_good      = in_req & bus.imem_ack & ~bus.branch_taken & ~pending_valid;
    assign load_seq        = fetch_good;
    assign load_target     = bus.branch_taken & ((in_req & bus.imem_ack) | in_hold);
    assign load_pending    = in_req & bus.imem_ack & ~bus.branch_taken & pending_valid;
    assign capture_pending = in_req & ~bus.imem_ack & bus.branch_taken;

    pc_register #(
        .RESET_VECTOR (RESET_VECTOR),
        .PC_INC       (PC_INC)
    ) u_pc_register (
        .clock           (clock),
        .reset           (reset),
        .load_seq        (load_seq),
        .load_target     (load_target),
        .load_pending    (load_pending),
        .capture_pending (capture_pending),
        .target          (bus.branch_target),
        .pc              (pc),
        .pending_valid   (pending_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (fetch_good) begin
                        instr_word  <= bus.imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.branch_taken || bus.instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_word  = instr_word;
    assign bus.instr_pc    = instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; memory returns word = address.
module tb_fetch_sequencer;
    import mips_fetch_pkg::*;

    logic  clock;
    logic  reset;
    logic  ack_en;
    logic  instr_ready;
    logic  branch_taken;
    word_t branch_target;

    int checks;
    int failures;

    fetch_sequencer_if bus();

    assign bus.imem_ack      = bus.imem_req & ack_en;
    assign bus.imem_rdata    = bus.imem_addr;
    assign bus.instr_ready   = instr_ready;
    assign bus.branch_taken  = branch_taken;
    assign bus.branch_target = branch_target;

    fetch_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .PC_INC       (32'd4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic br, input word_t tgt, input logic ack);
        instr_ready   = ready;
        branch_taken  = br;
        branch_target = tgt;
        ack_en        = ack;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expectReq(input string tag, input word_t addr);
        checkOutput({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        checkOutput({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic expectHold(input string tag, input word_t word, input word_t pc, input word_t addr);
        checkOutput({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        checkOutput({tag, "_word"}, bus.instr_word, word);
        checkOutput({tag, "_pc"}, bus.instr_pc, pc);
        checkOutput({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
        checkOutput({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) step();

        checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("rst_word", bus.instr_word, 32'h0);
        checkOutput("rst_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_addr", bus.imem_addr, 32'h0);

        reset = 1'b0;
        checkOutput("idle_req", {31'd0, bus.imem_req}, 32'd0);

        step();
        expectReq("boot0", 32'h0);
        checkOutput("boot0_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        expectHold("hold0", 32'h0, 32'h0, 32'h4);
        step();
        expectReq("boot4", 32'h4);
        step();
        expectHold("hold4", 32'h4, 32'h4, 32'h8);

        // Decode stalls: everything must freeze in HOLD.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            expectHold("bp", 32'h4, 32'h4, 32'h8);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        expectReq("bp_rel", 32'h8);
        checkOutput("bp_rel_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        expectHold("hold8", 32'h8, 32'h8, 32'hC);
        step();
        expectReq("reqC", 32'hC);
        step();
        expectHold("holdC", 32'hC, 32'hC, 32'h10);
        step();
        expectReq("req10", 32'h10);
        step();
        expectHold("hold10", 32'h10, 32'h10, 32'h14);

        // Redirect while holding 0x10 with decode ready: flush wins.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        step();
        checkOutput("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
        expectReq("flush", 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        expectHold("hold200", 32'h200, 32'h200, 32'h204);

        // Slow memory at 0x20 with two redirects arriving before the ack.
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
        step();
        expectReq("wait0", 32'h20);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0);
        step();
        expectReq("wait1", 32'h20);
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0);
        step();
        expectReq("wait2", 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        expectReq("wait3", 32'h20);
        checkOutput("wait3_valid", {31'd0, bus.instr_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        expectReq("discard", 32'h400);
        checkOutput("discard_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        expectHold("hold400", 32'h400, 32'h400, 32'h404);

        // Unaligned target near the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        expectReq("wrap", 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        expectHold("holdwrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
        step();
        expectReq("req0b", 32'h0);
        step();
        expectHold("hold0b", 32'h0, 32'h0, 32'h4);

        // Reset lands between edges while a fetch at 0x4 is outstanding.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        expectReq("pre_rst", 32'h4);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_req", {31'd0, bus.imem_req}, 32'd0);
        checkOutput("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("arst_addr", bus.imem_addr, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        expectReq("restart", 32'h0);
        step();
        expectHold("restart_hold", 32'h0, 32'h0, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences every PC update in the MIPS datapath. It issues one request/acknowledge transaction per instruction to instruction memory and holds each fetched word in an output register until decode accepts it. It also applies branch/jump redirects from the execute stage, discarding any fetch that a redirect makes stale. It sits between instruction memory and the decode stage and replaces free-running PC advance with a stall-aware, handshake-driven one.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- PC_INC, 4, sequential PC increment in bytes

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals current PC
- imem_ack  in  1  memory has returned imem_rdata this cycle; may be combinational in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_valid  out  1  instr_word/instr_pc hold an instruction for decode
- instr_word  out  32  fetched instruction
- instr_pc  out  32  address instr_word was fetched from
- instr_ready  in  1  decode accepts instruction when instr_valid=1
- branch_taken  in  1  single-cycle redirect strobe from execute
- branch_target  in  32  redirect address; bits [1:0] ignored, forced to 0

## Operation
- States: IDLE, REQ, HOLD.
- Reset (async, any state, mid-transaction included): state=IDLE, pc=RESET_VECTOR, pending flag=0, imem_req=0, instr_valid=0, instr_word=0, instr_pc=0. Any in-flight memory transaction is abandoned.
- IDLE: outputs quiet. Next edge -> REQ.
- REQ: imem_req=1, imem_addr=pc. imem_addr is stable while imem_req=1 and no ack has arrived.
  - branch_taken without imem_ack: latch pending target; stay REQ; pc unchanged until ack.
  - imem_ack with a pending redirect, or with branch_taken in the same cycle: discard imem_rdata. pc<=target, where a same-cycle branch_target beats the pending target. Clear pending; stay REQ.
  - imem_ack, no redirect: instr_word<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_INC, -> HOLD.
- HOLD: imem_req=0; outputs held stable while instr_ready=0.
  - branch_taken: instr_valid<=0 (flush), pc<=branch_target, -> REQ. This takes priority over instr_ready in the same cycle; the flushed instruction counts as not accepted.
  - instr_valid & instr_ready: instr_valid<=0, -> REQ.
- Multiple branch_taken pulses before an ack: last one wins.
- Arithmetic: pc+PC_INC is modulo 2^32; 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.

## Timing
- Reset release at edge 0: IDLE. Edge 1 -> REQ; imem_req=1 in cycle 1.
- Zero-wait memory (ack in same cycle as req): instr_valid rises one edge after ack. Peak throughput is one instruction per 2 cycles (REQ, HOLD).
- Redirect latency: a branch_taken in HOLD puts imem_addr=target on the very next cycle. In REQ it takes effect on the cycle after the outstanding ack.
- All outputs are registered, except imem_addr, which is a direct copy of the pc register.

## Structure
- Shared package mips_fetch_pkg holds: fetch_state_t enum {IDLE, REQ, HOLD}, RESET_VECTOR default, PC_INC, and 32-bit word typedef.
- One sub-module is natural: pc_register. It contains the pc flop, the pending-target flop and flag, and the next-PC mux (sequential / same-cycle target / pending target). The FSM and output register stay in the top level.

## Test plan
- Reset: hold reset, then release with zero-wait memory returning word = address. Required: imem_addr 0x0, 0x4, 0x8 in turn; instr_pc/instr_word pairs (0x0,0x0), (0x4,0x4); instr_valid=0 until one edge after the first ack.
- Backpressure: instr_ready=0 for 5 cycles in HOLD. Required: instr_word/instr_pc unchanged, imem_req=0, no PC advance; one instruction accepted after instr_ready=1.
- Redirect in HOLD: holding pc 0x10 instruction, assert branch_taken with branch_target=0x200 while instr_ready=1. Required: instruction flushed (never accepted), next imem_addr=0x200.
- Redirect during wait: ack delayed 3 cycles at 0x20. Pulse branch_taken to 0x300, then to 0x400. Required: imem_addr stays 0x20 until ack, ack data discarded, next imem_addr=0x400.
- Branch target alignment and wrap: branch_target=0xFFFF_FFFF. Required: imem_addr=0xFFFF_FFFC, next sequential fetch address 0x0.
- Async reset mid-fetch: assert reset between clock edges while in REQ awaiting ack. Required: imem_req, instr_valid immediately 0; after release pc restarts at RESET_VECTOR.
